// File: rtl/mux_tree_pipe_if.sv
// mux_tree_pipe_if
//   Bundles the input-side and output-side handshake of mux_tree_pipe.
//   The slave modport is the mux's view and the master modport is the view of
//   whatever drives and consumes it.
//
//   Parameters : WIDTH  bits per channel
//                NUM_IN number of channels (SEL_W is derived from it)
//   Signals    : in_data/in_sel/in_valid/in_ready    input beat and handshake
//                out_data/out_sel/out_err/out_valid  output beat
//                out_ready                           downstream accept
//                scan_en                             present only when
//                                                    MUX_TREE_SCAN_EN is defined
interface mux_tree_pipe_if #(
    parameter int WIDTH  = 1,
    parameter int NUM_IN = 16
);
    localparam int SEL_W = $clog2(NUM_IN);

    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]        in_sel;
    logic                    in_valid;
    logic                    in_ready;
`ifdef MUX_TREE_SCAN_EN
    logic                    scan_en;
`endif
    logic [WIDTH-1:0]        out_data;
    logic [SEL_W-1:0]        out_sel;
    logic                    out_err;
    logic                    out_valid;
    logic                    out_ready;

`ifdef MUX_TREE_SCAN_EN
    modport slave (
        input  in_data, in_sel, in_valid, scan_en, out_ready,
        output in_ready, out_data, out_sel, out_err, out_valid
    );
    modport master (
        output in_data, in_sel, in_valid, scan_en, out_ready,
        input  in_ready, out_data, out_sel, out_err, out_valid
    );
`else
    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data, out_sel, out_err, out_valid
    );
    modport master (
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data, out_sel, out_err, out_valid
    );
`endif
endinterface

// File: rtl/mux_tree_pipe.sv
// mux_tree_pipe
//   Pipelined NUM_IN-to-1 multiplexer. Each pipeline stage registers one 4:1
//   level of the tree, so the critical path is a single 4:1 mux regardless of
//   NUM_IN. A valid/ready handshake travels alongside the data and every stage
//   advances together (no bubble squeezing).
//
//   Optional feature: define MUX_TREE_SCAN_EN to add bus.scan_en and an
//   internal channel counter that replaces in_sel while scan_en is high.
//
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous active-high reset; drops every in-flight beat
//     bus  mux_tree_pipe_if.slave (in_* beat in, out_* beat out)
module mux_tree_pipe #(
    parameter int WIDTH  = 1,
    parameter int NUM_IN = 16
) (
    input  logic          clk,
    input  logic          rst,
    mux_tree_pipe_if.slave bus
);
    localparam int SEL_W  = $clog2(NUM_IN);
    localparam int STAGES = (SEL_W + 1) / 2;
    localparam int SELX   = 2 * STAGES;
    localparam int LEAVES = 1 << (2 * STAGES);

    // All stage partial results live in one array; stage k starts at
    // node_off(k) and holds 4^(STAGES-1-k) entries.
    function automatic int node_off(input int k);
        int acc;
        acc = 0;
        for (int m = 0; m < k; m++) begin
            acc += 1 << (2 * (STAGES - 1 - m));
        end
        return acc;
    endfunction

    localparam int TOTAL    = node_off(STAGES);
    localparam int LAST_OFF = node_off(STAGES - 1);

    function automatic logic [WIDTH-1:0] mux4(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [WIDTH-1:0] c,
        input logic [WIDTH-1:0] d,
        input logic [1:0]       s
    );
        case (s)
            2'd0:    return a;
            2'd1:    return b;
            2'd2:    return c;
            default: return d;
        endcase
    endfunction

    logic                adv;
    logic [WIDTH-1:0]    pad_in    [LEAVES];
    logic [WIDTH-1:0]    node_reg  [TOTAL];
    logic [WIDTH-1:0]    node_next [TOTAL];
    logic [SEL_W-1:0]    sel_reg   [STAGES];
    logic [SEL_W-1:0]    sel_next  [STAGES];
    logic [STAGES-1:0]   err_reg;
    logic [STAGES-1:0]   err_next;
    logic [STAGES-1:0]   valid_reg;
    logic [STAGES-1:0]   valid_next;
    logic [SEL_W-1:0]    sel0;
    logic                err0;

    // The whole pipe moves as one: it only stalls when the output holds a
    // beat nobody is taking.
    assign adv          = !valid_reg[STAGES-1] || bus.out_ready;
    assign bus.in_ready = adv;

`ifdef MUX_TREE_SCAN_EN
    logic [SEL_W-1:0] scan_cnt_reg;
    logic [SEL_W-1:0] scan_cnt_next;

    // Counter sits at 0 whenever scan is off, so every scan run starts at
    // channel 0. It wraps at NUM_IN-1, never producing an out-of-range select.
    always_comb begin
        scan_cnt_next = scan_cnt_reg;
        if (!bus.scan_en) begin
            scan_cnt_next = '0;
        end else if (bus.in_valid && adv) begin
            if (32'(scan_cnt_reg) == NUM_IN - 1) begin
                scan_cnt_next = '0;
            end else begin
                scan_cnt_next = scan_cnt_reg + SEL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt_reg <= '0;
        end else begin
            scan_cnt_reg <= scan_cnt_next;
        end
    end

    assign sel0 = bus.scan_en ? scan_cnt_reg : bus.in_sel;
`else
    assign sel0 = bus.in_sel;
`endif

    assign err0 = (32'(sel0) >= NUM_IN);

    // Zero-pad the channel set up to a full 4-ary tree.
    for (genvar gi = 0; gi < LEAVES; gi++) begin : g_pad
        if (gi < NUM_IN) begin : g_ch
            assign pad_in[gi] = bus.in_data[gi*WIDTH +: WIDTH];
        end else begin : g_zero
            assign pad_in[gi] = '0;
        end
    end

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        localparam int OFF   = node_off(gi);
        localparam int NODES = 1 << (2 * (STAGES - 1 - gi));
        logic [1:0] pick;

        if (gi == 0) begin : g_first
            assign pick          = 2'(SELX'(sel0));
            assign sel_next[0]   = sel0;
            assign err_next[0]   = err0;
            assign valid_next[0] = bus.in_valid;
            // Out-of-range selects are zeroed here so later stages carry 0.
            for (genvar gj = 0; gj < NODES; gj++) begin : g_node
                assign node_next[OFF+gj] = err0 ? '0 :
                    mux4(pad_in[4*gj], pad_in[4*gj+1],
                         pad_in[4*gj+2], pad_in[4*gj+3], pick);
            end
        end else begin : g_later
            localparam int PREV = node_off(gi - 1);
            // Each stage consumes the next two select bits of the beat it
            // is working on, taken from the select carried by the prior stage.
            assign pick           = 2'(SELX'(sel_reg[gi-1]) >> (2 * gi));
            assign sel_next[gi]   = sel_reg[gi-1];
            assign err_next[gi]   = err_reg[gi-1];
            assign valid_next[gi] = valid_reg[gi-1];
            for (genvar gj = 0; gj < NODES; gj++) begin : g_node
                assign node_next[OFF+gj] =
                    mux4(node_reg[PREV+4*gj], node_reg[PREV+4*gj+1],
                         node_reg[PREV+4*gj+2], node_reg[PREV+4*gj+3], pick);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TOTAL; i++) begin
                node_reg[i] <= '0;
            end
            for (int i = 0; i < STAGES; i++) begin
                sel_reg[i] <= '0;
            end
            err_reg   <= '0;
            valid_reg <= '0;
        end else if (adv) begin
            node_reg  <= node_next;
            sel_reg   <= sel_next;
            err_reg   <= err_next;
            valid_reg <= valid_next;
        end
    end

    assign bus.out_data  = node_reg[LAST_OFF];
    assign bus.out_sel   = sel_reg[STAGES-1];
    assign bus.out_err   = err_reg[STAGES-1];
    assign bus.out_valid = valid_reg[STAGES-1];
endmodule

// File: tb/tb_mux_tree_pipe.sv
// tb_mux_tree_pipe
//   Three instances: 16x1 (two stages), 5x8 (two stages, padded tree) and
//   64x4 (three stages). Inputs are driven at the falling edge; outputs are
//   sampled 1 ns later, i.e. they show the state after the previous rising
//   edge. A beat driven at step t is therefore observed at step t+STAGES.
module tb_mux_tree_pipe;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int vec_cnt = 0;
    int err_cnt = 0;

    mux_tree_pipe_if #(.WIDTH(1), .NUM_IN(16)) b16 ();
    mux_tree_pipe_if #(.WIDTH(8), .NUM_IN(5))  b5  ();
    mux_tree_pipe_if #(.WIDTH(4), .NUM_IN(64)) b64 ();

    mux_tree_pipe #(.WIDTH(1), .NUM_IN(16)) dut16 (.clk(clk), .rst(rst), .bus(b16));
    mux_tree_pipe #(.WIDTH(8), .NUM_IN(5))  dut5  (.clk(clk), .rst(rst), .bus(b5));
    mux_tree_pipe #(.WIDTH(4), .NUM_IN(64)) dut64 (.clk(clk), .rst(rst), .bus(b64));

    logic [15:0] pat16 = 16'hA5C3;
    logic [7:0]  chan5 [5] = '{8'h11, 8'h22, 8'h33, 8'h7E, 8'h44};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic step16(input string tag, input logic iv, input logic [3:0] sel,
                          input logic eov, input logic [3:0] esel, input logic edata);
        @(negedge clk);
        b16.in_valid = iv; b16.in_sel = sel; b16.out_ready = 1'b1;
        #1;
        check({tag, " rdy"}, b16.in_ready, 1'b1);
        check({tag, " ov"}, b16.out_valid, eov);
        if (eov) begin
            check({tag, " sel"}, b16.out_sel, esel);
            check({tag, " data"}, b16.out_data, edata);
        end
    endtask

    task automatic step5(input string tag, input logic iv, input logic [2:0] sel,
                         input logic ord, input logic erdy, input logic eov,
                         input logic [2:0] esel, input logic [7:0] edata, input logic eerr);
        @(negedge clk);
        b5.in_valid = iv; b5.in_sel = sel; b5.out_ready = ord;
        #1;
        check({tag, " rdy"}, b5.in_ready, erdy);
        check({tag, " ov"}, b5.out_valid, eov);
        if (eov) begin
            check({tag, " sel"}, b5.out_sel, esel);
            check({tag, " data"}, b5.out_data, edata);
            check({tag, " err"}, b5.out_err, eerr);
        end
    endtask

    task automatic step64(input string tag, input logic r, input logic iv,
                          input logic [5:0] sel, input logic all, input logic eov,
                          input logic [5:0] esel, input logic [3:0] edata, input logic eerr);
        @(negedge clk);
        rst = r; b64.in_valid = iv; b64.in_sel = sel; b64.out_ready = 1'b1;
        #1;
        check({tag, " ov"}, b64.out_valid, eov);
        if (eov || all) begin
            check({tag, " sel"}, b64.out_sel, esel);
            check({tag, " data"}, b64.out_data, edata);
            check({tag, " err"}, b64.out_err, eerr);
        end
    endtask

    initial begin
        rst = 1'b1;
        b16.in_data = pat16;   b16.in_sel = '0; b16.in_valid = 1'b0; b16.out_ready = 1'b1;
        b5.in_data  = {chan5[4], chan5[3], chan5[2], chan5[1], chan5[0]};
        b5.in_sel = '0; b5.in_valid = 1'b0; b5.out_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            b64.in_data[i*4 +: 4] = 4'(i);
        end
        b64.in_sel = '0; b64.in_valid = 1'b0; b64.out_ready = 1'b1;
`ifdef MUX_TREE_SCAN_EN
        b16.scan_en = 1'b0; b5.scan_en = 1'b0; b64.scan_en = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset16 ov",   b16.out_valid, 1'b0);
        check("reset16 data", b16.out_data,  1'b0);
        check("reset16 sel",  b16.out_sel,   4'd0);
        check("reset16 err",  b16.out_err,   1'b0);
        check("reset5 ov",    b5.out_valid,  1'b0);
        check("reset5 data",  b5.out_data,   8'h00);
        check("reset64 ov",   b64.out_valid, 1'b0);
        check("reset64 sel",  b64.out_sel,   6'd0);
        rst = 1'b0;

        // Sweep all 16 selects of 16'hA5C3.
        for (int t = 0; t < 18; t++) begin
            step16($sformatf("sweep t%0d", t), t < 16, 4'(t), t >= 2,
                   4'(t - 2), (t >= 2) ? pat16[t-2] : 1'b0);
        end

        // Padded tree: in-range and out-of-range selects.
        step5("np s3", 1, 3'd3, 1, 1, 0, 3'd0, 8'h00, 0);
        step5("np s6", 1, 3'd6, 1, 1, 0, 3'd0, 8'h00, 0);
        step5("np s4", 1, 3'd4, 1, 1, 1, 3'd3, 8'h7E, 0);
        step5("np s7", 1, 3'd7, 1, 1, 1, 3'd6, 8'h00, 1);
        step5("np s5", 1, 3'd5, 1, 1, 1, 3'd4, 8'h44, 0);
        step5("np f1", 0, 3'd0, 1, 1, 1, 3'd7, 8'h00, 1);
        step5("np f2", 0, 3'd0, 1, 1, 1, 3'd5, 8'h00, 1);
        step5("np f3", 0, 3'd0, 1, 1, 0, 3'd0, 8'h00, 0);

        // Backpressure: three stalled cycles once the first output shows up.
        step5("bp 0", 1, 3'd0, 1, 1, 0, 3'd0, 8'h00, 0);
        step5("bp 1", 1, 3'd1, 1, 1, 0, 3'd0, 8'h00, 0);
        step5("bp 2", 1, 3'd2, 0, 0, 1, 3'd0, 8'h11, 0);
        step5("bp 3", 1, 3'd2, 0, 0, 1, 3'd0, 8'h11, 0);
        step5("bp 4", 1, 3'd2, 0, 0, 1, 3'd0, 8'h11, 0);
        step5("bp 5", 1, 3'd2, 1, 1, 1, 3'd0, 8'h11, 0);
        step5("bp 6", 1, 3'd3, 1, 1, 1, 3'd1, 8'h22, 0);
        step5("bp 7", 0, 3'd0, 1, 1, 1, 3'd2, 8'h33, 0);
        step5("bp 8", 0, 3'd0, 1, 1, 1, 3'd3, 8'h7E, 0);
        step5("bp 9", 0, 3'd0, 1, 1, 0, 3'd0, 8'h00, 0);

        // Bubbles: in_valid 1,0,1,0... reappears two steps later.
        for (int t = 0; t < 10; t++) begin
            step16($sformatf("bub t%0d", t), (t < 8) && (t % 2 == 0), 4'(t),
                   (t >= 2) && (t < 10) && (t % 2 == 0), 4'(t - 2),
                   (t >= 2) ? pat16[t-2] : 1'b0);
        end

        // Three-stage tree: one clean beat, then reset with two in flight.
        step64("d64 a", 0, 1, 6'd37, 0, 0, 6'd0, 4'h0, 0);
        step64("d64 b", 0, 0, 6'd0,  0, 0, 6'd0, 4'h0, 0);
        step64("d64 c", 0, 0, 6'd0,  0, 0, 6'd0, 4'h0, 0);
        step64("d64 d", 0, 0, 6'd0,  0, 1, 6'd37, 4'h5, 0);
        step64("d64 e", 0, 0, 6'd0,  0, 0, 6'd0, 4'h0, 0);
        step64("rst a", 0, 1, 6'd10, 0, 0, 6'd0, 4'h0, 0);
        step64("rst b", 0, 1, 6'd20, 0, 0, 6'd0, 4'h0, 0);
        step64("rst c", 1, 0, 6'd0,  0, 0, 6'd0, 4'h0, 0);
        step64("rst d", 0, 0, 6'd0,  1, 0, 6'd0, 4'h0, 0);
        step64("rst e", 0, 0, 6'd0,  1, 0, 6'd0, 4'h0, 0);
        step64("rst f", 0, 0, 6'd0,  1, 0, 6'd0, 4'h0, 0);

`ifdef MUX_TREE_SCAN_EN
        // Scan: in_sel is held at an illegal value to show it is ignored.
        b5.scan_en = 1'b1;
        for (int t = 0; t < 9; t++) begin
            step5($sformatf("scan t%0d", t), t < 7, 3'd7, 1, 1, t >= 2,
                  3'((t + 3) % 5), chan5[(t + 3) % 5], 0);
        end
        b5.scan_en = 1'b0;
        step5("scan off", 0, 3'd7, 1, 1, 0, 3'd0, 8'h00, 0);
        b5.scan_en = 1'b1;
        step5("rescan 0", 1, 3'd7, 1, 1, 0, 3'd0, 8'h00, 0);
        step5("rescan 1", 1, 3'd7, 1, 1, 0, 3'd0, 8'h00, 0);
        step5("rescan 2", 0, 3'd7, 1, 1, 1, 3'd0, 8'h11, 0);
        step5("rescan 3", 0, 3'd7, 1, 1, 1, 3'd1, 8'h22, 0);
        b5.scan_en = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule

// File: doc/mux_tree_pipe.md
# mux_tree_pipe

Parametrised, pipelined N-to-1 multiplexer for wide channel selection. It replaces flat combinational mux trees where NUM_IN or WIDTH is too large to close timing in one cycle. The block registers one 4:1 level per pipeline stage and carries a valid/ready handshake through the tree. An optional scan mode lets it sequence through all channels autonomously, as a time-division serializer.

## Interface
- WIDTH, 1: bits per input channel.
- NUM_IN, 16: number of input channels; legal range 2..256.
- SEL_W, $clog2(NUM_IN): select width (derived, not overridden).
- STAGES, (SEL_W+1)/2: pipeline depth, one 4:1 level per stage (derived).

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  NUM_IN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_sel  in  SEL_W  channel to select.
- in_valid  in  1  beat present on in_data/in_sel.
- in_ready  out  1  block accepts beat this cycle.
- scan_en  in  1  scan mode request (only with MUX_TREE_SCAN_EN).
- out_data  out  WIDTH  selected channel.
- out_sel  out  SEL_W  select value that produced out_data.
- out_err  out  1  selected index was >= NUM_IN; out_data is then 0.
- out_valid  out  1  out_data/out_sel/out_err valid.
- out_ready  in  1  downstream accepts output.

## Operation
- Inputs are padded to 4^STAGES channels with zeros. Select is zero-extended to 2*STAGES bits.
- Stage k (k = 0..STAGES-1) resolves select bits [2k+1:2k]:
  - It holds 4^(STAGES-1-k) partial results of WIDTH bits.
  - It also holds the full select, the err flag and a valid bit.
- Stage 0 captures in_data reduced by sel[1:0]. Its err bit is computed as sel >= NUM_IN.
- The last stage drives out_data, out_sel, out_err and out_valid.
- out_data is forced to 0 whenever err is set.
- Global advance: adv = !out_valid || out_ready. All stages shift together when adv=1. They all hold when adv=0.
- in_ready = adv. A beat is accepted when in_valid && in_ready.
- Stage 0 loads valid = in_valid when adv=1. Bubbles propagate as valid=0 and are not squeezed out.
- Reset: every valid bit, data register, select register and err bit clears to 0. After reset, out_valid=0, out_data=0, out_sel=0 and out_err=0.
- Reset mid-operation discards all in-flight beats. No output beat is produced for them.

## Timing
- Latency: a beat accepted at edge n appears at out_valid after edge n+STAGES-1, then holds until it is consumed. With the default NUM_IN=16, STAGES=2, so the first output is visible one cycle after acceptance.
- Throughput: one beat per cycle while out_ready=1.
- Backpressure: out_valid=1 with out_ready=0 holds every stage, and in_ready drops combinationally in the same cycle.
- in_ready depends combinationally on out_ready. There is no combinational path from in_data to out_data.
- out_* signals are stable while out_valid=1 and out_ready=0.

## Configuration
- MUX_TREE_SCAN_EN defined:
  - Adds the scan_en port and a SEL_W-bit scan counter that resets to 0.
  - While scan_en=1, stage 0 uses the counter in place of in_sel. The counter increments on each accepted beat and wraps from NUM_IN-1 to 0, so out_err is never set in scan mode.
  - While scan_en=0, the counter is held at 0.
  - Deasserting and reasserting scan_en restarts the scan at channel 0.
- MUX_TREE_SCAN_EN undefined: no scan_en port and no counter. The select is always in_sel.

## Test plan
- Reset/basic, NUM_IN=16, WIDTH=1: in_data=16'hA5C3, sweep in_sel 0..15 with out_ready=1 -> out_data follows bits of 16'hA5C3 one cycle after acceptance, and out_sel echoes in_sel.
- Non-power-of-4, NUM_IN=5, WIDTH=8: in_sel=3 with channel 3=8'h7E -> out_data=8'h7E and out_err=0. in_sel=6 -> out_data=0 and out_err=1.
- Backpressure: stream sel 0,1,2,3; hold out_ready=0 for 3 cycles after the first output -> in_ready=0 and outputs frozen. On release, all four beats arrive in order with none lost or duplicated.
- Bubbles: alternate in_valid 1/0 -> out_valid alternates identically, delayed by STAGES-1 cycles.
- Reset mid-stream: assert rst with 2 beats in flight (NUM_IN=64, STAGES=3) -> all outputs 0 next cycle, and no stale beat emerges afterwards.
- Scan (macro defined), NUM_IN=5: scan_en=1, in_valid=1, out_ready=1 for 7 beats -> out_sel sequence 0,1,2,3,4,0,1. Toggling scan_en low then high restarts at 0.
